// File: rtl/eddsa_msg_feeder_pkg.sv
// ---------------------------------------------------------------------------
// eddsa_msg_feeder_pkg
// Shared definitions for the EdDSA message front end:
//   - block_valid encodings presented to the EdDSA core
//   - feeder state enumeration
//   - default word and block widths
// ---------------------------------------------------------------------------
package eddsa_msg_feeder_pkg;

  localparam int unsigned DEF_WIDTH      = 64;
  localparam int unsigned DEF_SIZE_BLOCK = 1024;

  // block_valid encodings: MORE = intermediate block, LAST = final block.
  localparam logic [1:0] BV_NONE = 2'b00;
  localparam logic [1:0] BV_MORE = 2'b10;
  localparam logic [1:0] BV_LAST = 2'b01;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage : eddsa_msg_feeder_pkg

// File: rtl/rise_detect.sv
// ---------------------------------------------------------------------------
// rise_detect
// Rising-edge detector for a level input that is synchronous to clk.
// The previous level is held in a register; rise_o is high for the one
// cycle in which sig_i is high and was low on the previous clock.
// Ports:
//   clk    - clock
//   rst    - asynchronous active-low reset
//   sig_i  - level to watch
//   rise_o - one-cycle rising-edge indication
// ---------------------------------------------------------------------------
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic sig_i,
  output logic rise_o
);

  logic prev_q;

  // NOTE: state is updated with non-blocking assignments so that every
  // register samples the values from before the clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= sig_i;
    end
  end

  assign rise_o = sig_i & ~prev_q;

endmodule : rise_detect

// File: rtl/eddsa_msg_feeder.sv
// ---------------------------------------------------------------------------
// eddsa_msg_feeder
// Packs a stream of WIDTH-bit message words MSB-first into SIZE_BLOCK-bit
// blocks, zeroes the bits past len_message, and hands each block to the
// EdDSA core on a block_ready rising edge. The assembly buffer refills
// while the core holds the previous block in the output register.
// Ports:
//   clk, rst     - clock, asynchronous active-low reset
//   start        - begins a message (accepted only in IDLE)
//   len_message  - message length in bits, sampled on start
//   din          - message word, first message bit in din[WIDTH-1]
//   din_valid    - din valid
//   din_ready    - word accepted when din_valid && din_ready
//   block_ready  - request level from the core, acted on at its rising edge
//   message      - block presented to the core
//   block_valid  - 00 none, 10 intermediate block, 01 final block
//   busy         - message in progress
//   done         - one-cycle pulse when the final block is presented
//   error        - sticky: request edge with no message active
// ---------------------------------------------------------------------------
module eddsa_msg_feeder
  import eddsa_msg_feeder_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned SIZE_BLOCK = DEF_SIZE_BLOCK
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      len_message,
  input  logic [WIDTH-1:0]      din,
  input  logic                  din_valid,
  output logic                  din_ready,
  input  logic                  block_ready,
  output logic [SIZE_BLOCK-1:0] message,
  output logic [1:0]            block_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int unsigned WPB    = SIZE_BLOCK / WIDTH;
  localparam int unsigned SLOT_W = (WPB > 1) ? $clog2(WPB) : 1;
  localparam logic [WIDTH-1:0] W_L = WIDTH'(WIDTH);
  localparam logic [WIDTH-1:0] B_L = WIDTH'(SIZE_BLOCK);

  state_e state_q, state_d;

  logic [WIDTH-1:0]      word_cnt_q, word_cnt_d;
  logic [WIDTH-1:0]      blk_cnt_q,  blk_cnt_d;
  logic [WIDTH-1:0]      words_q,    words_d;
  logic [WIDTH-1:0]      blocks_q,   blocks_d;
  logic [WIDTH-1:0]      rem_q,      rem_d;
  logic [SLOT_W-1:0]     slot_q,     slot_d;
  logic [SIZE_BLOCK-1:0] asm_buf_q,  asm_buf_d;
  logic [SIZE_BLOCK-1:0] message_q,  message_d;
  logic [1:0]            bv_q,       bv_d;
  logic                  pending_q,  pending_d;
  logic                  error_q,    error_d;

  logic                  br_rise;
  logic                  accept;
  logic                  last_word;
  logic                  slot_last;
  logic                  is_final;
  logic                  xfer;
  logic [WIDTH-1:0]      len_rem;
  logic [WIDTH-1:0]      len_words;
  logic [WIDTH-1:0]      len_blocks_raw;
  logic [WIDTH-1:0]      len_blocks;
  logic [WIDTH-1:0]      last_mask;
  logic [WIDTH-1:0]      word_in;

  rise_detect u_rise_detect (
    .clk    (clk),
    .rst    (rst),
    .sig_i  (block_ready),
    .rise_o (br_rise)
  );

  // Length-derived values, latched when a message starts. A zero-length
  // message still produces one (all-zero) final block.
  assign len_rem        = len_message % W_L;
  assign len_words      = (len_message / W_L) + WIDTH'(len_rem != '0);
  assign len_blocks_raw = (len_message / B_L) + WIDTH'((len_message % B_L) != '0);
  assign len_blocks     = (len_blocks_raw == '0) ? WIDTH'(1) : len_blocks_raw;

  assign accept    = din_valid && din_ready;
  assign last_word = (word_cnt_q == words_q - WIDTH'(1));
  assign slot_last = (slot_q == SLOT_W'(WPB - 1));
  assign is_final  = (blk_cnt_q == blocks_q - WIDTH'(1));
  assign xfer      = (state_q == FULL) && pending_q;

  // Keep only the top rem_q bits of the final word; a full final word
  // (rem_q == 0) passes unchanged.
  assign last_mask = (rem_q == '0) ? '1 : ~({WIDTH{1'b1}} >> rem_q);
  assign word_in   = last_word ? (din & last_mask) : din;

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------
  // NOTE: every signal assigned in a combinational block gets a default
  // first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = (len_message == '0) ? FULL : FILL;
      FILL: if (accept && (slot_last || last_word)) state_d = FULL;
      FULL: if (xfer) state_d = is_final ? DONE : FILL;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------
  always_comb begin
    din_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      FILL:    begin din_ready = 1'b1; busy = 1'b1; end
      FULL:    busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath next state
  // ---------------------------------------------------------------------
  always_comb begin
    word_cnt_d = word_cnt_q;
    blk_cnt_d  = blk_cnt_q;
    words_d    = words_q;
    blocks_d   = blocks_q;
    rem_d      = rem_q;
    slot_d     = slot_q;
    asm_buf_d  = asm_buf_q;
    message_d  = message_q;
    bv_d       = bv_q;
    pending_d  = pending_q;
    error_d    = error_q;

    // Slot 0 sits in the most significant WIDTH bits of the block.
    if (accept) begin
      for (int unsigned s = 0; s < WPB; s++) begin
        if (slot_q == SLOT_W'(s)) begin
          asm_buf_d[(WPB - 1 - s) * WIDTH +: WIDTH] = word_in;
        end
      end
      word_cnt_d = word_cnt_q + WIDTH'(1);
      slot_d     = slot_last ? '0 : slot_q + SLOT_W'(1);
    end

    if (xfer) begin
      message_d = asm_buf_q;
      bv_d      = is_final ? BV_LAST : BV_MORE;
      asm_buf_d = '0;
      blk_cnt_d = blk_cnt_q + WIDTH'(1);
      pending_d = 1'b0;
    end

    // A request during a message is remembered until the block is full;
    // one that lands on the transfer cycle is a fresh request and wins.
    // Outside a message it either retires the presented block or is an
    // error when nothing is presented.
    if (br_rise) begin
      if (busy) begin
        pending_d = 1'b1;
      end else if (bv_q != BV_NONE) begin
        bv_d = BV_NONE;
      end else begin
        error_d = 1'b1;
      end
    end

    if ((state_q == IDLE) && start) begin
      word_cnt_d = '0;
      blk_cnt_d  = '0;
      slot_d     = '0;
      asm_buf_d  = '0;
      words_d    = len_words;
      blocks_d   = len_blocks;
      rem_d      = len_rem;
      pending_d  = 1'b0;
      error_d    = 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  // NOTE: the block buffers are ordinary flops, not a RAM, so they take
  // the asynchronous reset and no partial block survives a reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_cnt_q <= '0;
      blk_cnt_q  <= '0;
      words_q    <= '0;
      blocks_q   <= '0;
      rem_q      <= '0;
      slot_q     <= '0;
      asm_buf_q  <= '0;
      message_q  <= '0;
      bv_q       <= BV_NONE;
      pending_q  <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      word_cnt_q <= word_cnt_d;
      blk_cnt_q  <= blk_cnt_d;
      words_q    <= words_d;
      blocks_q   <= blocks_d;
      rem_q      <= rem_d;
      slot_q     <= slot_d;
      asm_buf_q  <= asm_buf_d;
      message_q  <= message_d;
      bv_q       <= bv_d;
      pending_q  <= pending_d;
      error_q    <= error_d;
    end
  end

  assign message     = message_q;
  assign block_valid = bv_q;
  assign error       = error_q;

endmodule : eddsa_msg_feeder

// File: tb/tb_eddsa_msg_feeder.sv
// ---------------------------------------------------------------------------
// tb_eddsa_msg_feeder
// Directed self-checking bench for eddsa_msg_feeder (WIDTH=64,
// SIZE_BLOCK=1024). Expected blocks come from the bench's own word table
// and a bit-level masking model; single-word results are hand-computed.
// ---------------------------------------------------------------------------
module tb_eddsa_msg_feeder;
  import eddsa_msg_feeder_pkg::*;

  localparam int W   = 64;
  localparam int SB  = 1024;
  localparam int WPB = SB / W;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  len_message = '0;
  logic [W-1:0]  din = '0;
  logic          din_valid = 1'b0;
  logic          din_ready;
  logic          block_ready = 1'b0;
  logic [SB-1:0] message;
  logic [1:0]    block_valid;
  logic          busy;
  logic          done;
  logic          error;

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] mem [0:127];

  eddsa_msg_feeder #(.WIDTH(W), .SIZE_BLOCK(SB)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .len_message (len_message),
    .din         (din),
    .din_valid   (din_valid),
    .din_ready   (din_ready),
    .block_ready (block_ready),
    .message     (message),
    .block_valid (block_valid),
    .busy        (busy),
    .done        (done),
    .error       (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected 64-bit slot s of block b for a message of len bits taken from mem.
  function automatic logic [63:0] exp_slot(input int b, input int s, input int len);
    int          idx;
    int          nw;
    int          r;
    logic [63:0] w;
    idx = b * WPB + s;
    nw  = (len + 63) / 64;
    if (idx >= nw) return 64'h0;
    w = mem[idx];
    r = len % 64;
    if ((idx == nw - 1) && (r != 0)) begin
      for (int k = 0; k < 64 - r; k++) w[k] = 1'b0;
    end
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int len);
    len_message = 64'(len);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Returns just after the edge that sampled block_ready high.
  task automatic pulse_br();
    block_ready = 1'b1;
    tick();
    block_ready = 1'b0;
  endtask

  task automatic feed(input int n, input int budget);
    int   k;
    int   guard;
    logic acc;
    k = 0;
    guard = 0;
    while (k < n && guard < budget) begin
      din = mem[k];
      din_valid = 1'b1;
      @(negedge clk);
      acc = din_ready;
      tick();
      if (acc) k++;
      guard++;
    end
    din_valid = 1'b0;
    if (k < n) check("feed_timeout", 64'(k), 64'(n));
  endtask

  task automatic check_block(input string name, input int b, input int len);
    for (int s = 0; s < WPB; s++) begin
      check($sformatf("%s_b%0d_s%0d", name, b, s), message[(WPB-1-s)*64 +: 64], exp_slot(b, s, len));
    end
  endtask

  // Waits 40 cycles per block (the block is full by then), requests it and
  // checks the presented block one cycle after the request edge.
  task automatic run_blocks(input string name, input int len, input int nblk);
    for (int b = 0; b < nblk; b++) begin
      repeat (40) tick();
      check($sformatf("%s_stall_b%0d", name, b), 64'(din_ready), 64'(0));
      check($sformatf("%s_busy_b%0d", name, b), 64'(busy), 64'(1));
      pulse_br();
      tick();
      check($sformatf("%s_bv_b%0d", name, b), 64'(block_valid),
            64'((b == nblk - 1) ? BV_LAST : BV_MORE));
      check_block(name, b, len);
      check($sformatf("%s_done_b%0d", name, b), 64'(done), 64'((b == nblk - 1) ? 1 : 0));
      if (b == nblk - 1) begin
        tick();
        check($sformatf("%s_done_end", name), 64'(done), 64'(0));
        check($sformatf("%s_busy_end", name), 64'(busy), 64'(0));
      end
    end
  endtask

  task automatic load_pattern();
    for (int i = 0; i < 128; i++) begin
      mem[i] = {16'hC0DE, 16'(i), 32'h1234_5678 ^ 32'(i * 977)};
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_msg", message[SB-1 -: 64], 64'h0);
    check("rst_bv", 64'(block_valid), 64'(BV_NONE));
    check("rst_din_ready", 64'(din_ready), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_error", 64'(error), 64'(0));
    #3 rst = 1'b1;
    tick();

    // len=48: one word, low 16 bits must be masked off
    mem[0] = 64'h89010d855972_beef;
    do_start(48);
    check("t1_busy", 64'(busy), 64'(1));
    fork
      feed(1, 50);
      run_blocks("t1", 48, 1);
    join
    check("t1_slot0", message[SB-1 -: 64], 64'h89010d855972_0000);
    tick();
    pulse_br();
    check("t1_clear_bv", 64'(block_valid), 64'(BV_NONE));
    check("t1_clear_err", 64'(error), 64'(0));
    tick();

    // len=0: no words consumed, one all-zero final block
    mem[0] = 64'hdead_beef_dead_beef;
    din = mem[0];
    din_valid = 1'b1;
    do_start(0);
    check("t4_din_ready", 64'(din_ready), 64'(0));
    run_blocks("t4", 0, 1);
    din_valid = 1'b0;

    // Error: retire the held block, then a request with nothing presented
    tick();
    pulse_br();
    check("err_clear_bv", 64'(block_valid), 64'(BV_NONE));
    check("err_not_yet", 64'(error), 64'(0));
    tick();
    pulse_br();
    check("err_set", 64'(error), 64'(1));
    tick();

    // len=640: ten full words in one final block; start also clears error
    mem[0] = 64'h9aa19a59_5c3b6f4e;
    mem[1] = 64'h21d07a11_8e4c93b2;
    mem[2] = 64'hf05a7c3d_1b29e864;
    mem[3] = 64'h47c8b2e1_90ad3f56;
    mem[4] = 64'h6e1f04b9_d7a2c835;
    mem[5] = 64'hb38d5f72_0c6e91a4;
    mem[6] = 64'h5a0e2c97_f4b3186d;
    mem[7] = 64'hc92b8e40_7d15a3f6;
    mem[8] = 64'h1e74d6a3_b58c0f29;
    mem[9] = 64'h7d21c5a8_03ef19ee;
    do_start(640);
    check("err_cleared", 64'(error), 64'(0));
    fork
      feed(10, 100);
      run_blocks("t2", 640, 1);
    join

    // len=8184: 128 words, eight blocks, last word keeps its top 56 bits
    load_pattern();
    do_start(8184);
    fork
      feed(128, 1000);
      run_blocks("t3", 8184, 8);
    join
    check("t3_tail", 64'(message[7:0]), 64'h0);

    // Reset after 9 words of a 2048-bit message, then restart
    do_start(2048);
    feed(9, 50);
    #3 rst = 1'b0;
    #1;
    for (int s = 0; s < WPB; s++) begin
      check($sformatf("t6_rst_s%0d", s), message[(WPB-1-s)*64 +: 64], 64'h0);
    end
    check("t6_rst_bv", 64'(block_valid), 64'(BV_NONE));
    check("t6_rst_din_ready", 64'(din_ready), 64'(0));
    check("t6_rst_busy", 64'(busy), 64'(0));
    check("t6_rst_done", 64'(done), 64'(0));
    check("t6_rst_error", 64'(error), 64'(0));
    tick();
    #3 rst = 1'b1;
    tick();
    do_start(2048);
    fork
      feed(32, 300);
      run_blocks("t6", 2048, 2);
    join

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_eddsa_msg_feeder
